// File: rtl/cvp14_pkg.sv
// Shared CVP14 definitions: instruction function codes, vector geometry and the
// memory sequencer state type.
package cvp14_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 16;

  localparam logic [3:0] VADD = 4'b0000;
  localparam logic [3:0] VDOT = 4'b0001;
  localparam logic [3:0] SMUL = 4'b0010;
  localparam logic [3:0] SST  = 4'b0011;
  localparam logic [3:0] VLD  = 4'b0100;
  localparam logic [3:0] VST  = 4'b0101;
  localparam logic [3:0] SLL  = 4'b0110;
  localparam logic [3:0] SLH  = 4'b0111;
  localparam logic [3:0] J    = 4'b1000;
  localparam logic [3:0] NOP  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } vseq_state_t;

  function automatic logic is_mem_op(input logic [3:0] f);
    return (f == VLD) || (f == VST) || (f == SST);
  endfunction

endpackage

// File: rtl/vseq_addr_gen.sv
// Address generation for the memory sequencer: per-word address base+idx and
// the check whether a full vector starting at start_base runs past the top.
module vseq_addr_gen
  import cvp14_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  idx,
  input  logic [ADDR_W-1:0] start_base,
  output logic [ADDR_W-1:0] addr,
  output logic              span_ovf
);

  // Highest base whose last lane still fits without a carry out of ADDR_W.
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'((1 << ADDR_W) - LANES);

  assign addr     = base + ADDR_W'(idx);
  assign span_ovf = (start_base > MAX_BASE);

endmodule

// File: rtl/vec_mem_sequencer.sv
// Multi-cycle VLD/VST/SST memory sequencer with req/ack memory port.
// Optional macro VSEQ_ADDR_FAULT_EN: vector accesses whose span wraps past the
// top of memory are refused and reported through fault.
//
// Memory handshake: mem_req is held high in XFER with mem_we/mem_addr/mem_wdata
// stable; a word completes on any rising clk edge where mem_req && mem_ack,
// and the next word (if any) is presented in the following cycle.
module vec_mem_sequencer
  import cvp14_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [3:0]                functype,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [LANE_W-1:0]         scalar_wdata,
  input  logic [LANES*LANE_W-1:0]   vector_wdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LANE_W-1:0]         mem_wdata,
  input  logic [LANE_W-1:0]         mem_rdata,
  input  logic                      mem_ack,
  output logic [LANES*LANE_W-1:0]   load_data,
  output logic                      busy,
  output logic                      done,
  output logic                      fault
);

  localparam int IDX_W = $clog2(LANES);

  vseq_state_t               state_q, state_d;
  logic [3:0]                func_q;
  logic [ADDR_W-1:0]         base_q;
  logic [LANE_W-1:0]         sdata_q;
  logic [LANES*LANE_W-1:0]   vdata_q;
  logic [IDX_W-1:0]          idx_q;
  logic                      fault_q;
  logic [LANES*LANE_W-1:0]   load_q;

  logic [ADDR_W-1:0]         cur_addr;
  logic                      span_ovf;
  logic                      start_fault;
  logic                      is_last;
  logic [LANE_W-1:0]         lane_wdata;

  vseq_addr_gen #(
    .ADDR_W (ADDR_W),
    .IDX_W  (IDX_W)
  ) u_addr_gen (
    .base       (base_q),
    .idx        (idx_q),
    .start_base (base_addr),
    .addr       (cur_addr),
    .span_ovf   (span_ovf)
  );

`ifdef VSEQ_ADDR_FAULT_EN
  assign start_fault = ((functype == VLD) || (functype == VST)) && span_ovf;
`else
  logic unused_span_ovf;
  assign unused_span_ovf = span_ovf;
  assign start_fault     = 1'b0;
`endif

  assign is_last = (func_q == SST) || (idx_q == IDX_W'(LANES - 1));

  always_comb begin
    lane_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx_q == IDX_W'(i)) lane_wdata = vdata_q[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!is_mem_op(functype) || start_fault) state_d = DONE;
          else                                     state_d = XFER;
        end
      end
      XFER: begin
        if (mem_ack && is_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured at start so the execute stage may move on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q  <= '0;
      base_q  <= '0;
      sdata_q <= '0;
      vdata_q <= '0;
      idx_q   <= '0;
      fault_q <= 1'b0;
      load_q  <= '0;
    end else if (state_q == IDLE && start) begin
      func_q  <= functype;
      base_q  <= base_addr;
      sdata_q <= scalar_wdata;
      vdata_q <= vector_wdata;
      idx_q   <= '0;
      fault_q <= start_fault;
    end else if (state_q == XFER && mem_ack) begin
      idx_q <= idx_q + 1'b1;
      if (func_q == VLD) begin
        for (int i = 0; i < LANES; i++) begin
          if (idx_q == IDX_W'(i)) load_q[i*LANE_W +: LANE_W] <= mem_rdata;
        end
      end
    end
  end

  assign mem_req   = (state_q == XFER);
  assign mem_we    = mem_req && (func_q != VLD);
  assign mem_addr  = mem_req ? cur_addr : '0;
  assign mem_wdata = !mem_we ? '0 : ((func_q == VST) ? lane_wdata : sdata_q);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign fault     = done && fault_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: expected memory transfers and
// completions are queued at issue time and checked by an independent monitor.
module tb_vec_mem_sequencer;
  import cvp14_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   functype;
  logic [15:0]  base_addr;
  logic [15:0]  scalar_wdata;
  logic [255:0] vector_wdata;
  logic         mem_req, mem_we;
  logic [15:0]  mem_addr, mem_wdata, mem_rdata;
  logic         mem_ack;
  logic [255:0] load_data;
  logic         busy, done, fault;

  typedef struct {
    logic         fault;
    logic [255:0] ld;
    int           done_cyc;
  } done_t;

  logic [32:0]  exp_q[$];
  done_t        done_q[$];
  logic [255:0] ld_model = '0;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           xfer_cnt = 0;
  int           ack_mode = 0;
  int           phase = 0;
  logic [32:0]  mon_ent;
  done_t        mon_d;

  vec_mem_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .functype     (functype),
    .base_addr    (base_addr),
    .scalar_wdata (scalar_wdata),
    .vector_wdata (vector_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .load_data    (load_data),
    .busy         (busy),
    .done         (done),
    .fault        (fault)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory model: word at address A reads as A ^ 16'hA5A5
  assign mem_rdata = mem_addr ^ 16'hA5A5;

  initial mem_ack = 1'b0;
  always @(posedge clk) begin
    #1;
    case (ack_mode)
      0: mem_ack = 1'b1;
      1: begin
        phase   = (phase + 1) % 3;
        mem_ack = (phase == 0);
      end
      default: mem_ack = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        check("req_busy", busy, 1'b1);
        if (exp_q.size() == 0) begin
          check("req_unexpected", mem_req, 1'b0);
        end else begin
          mon_ent = exp_q[0];
          check("mem_we", mem_we, mon_ent[32]);
          check("mem_addr", mem_addr, mon_ent[31:16]);
          if (mon_ent[32]) check("mem_wdata", mem_wdata, mon_ent[15:0]);
          if (mem_ack) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", done, 1'b0);
        end else begin
          mon_d = done_q.pop_front();
          check("fault", fault, mon_d.fault);
          check("load_data", load_data, mon_d.ld);
          check("done_busy", busy, 1'b1);
          check("xfers_left", exp_q.size(), 0);
          if (mon_d.done_cyc >= 0) check("done_cycle", cyc, mon_d.done_cyc);
        end
      end
    end
  end

  // driver tasks
  task automatic push_and_start(input logic [3:0] f, input logic [15:0] b,
                                input logic [15:0] s, input logic [255:0] v, input int mode);
    done_t       d;
    int          lat;
    bit          flt;
    logic [15:0] a;
    @(negedge clk);
    ack_mode = mode;
    flt = 1'b0;
`ifdef VSEQ_ADDR_FAULT_EN
    flt = ((f == VLD) || (f == VST)) && ((32'(b) + LANES - 1) > 32'hFFFF);
`endif
    if (!is_mem_op(f) || flt) begin
      lat = 1;
    end else if (f == SST) begin
      lat = 2;
      exp_q.push_back({1'b1, b, s});
    end else begin
      lat = 17;
      for (int i = 0; i < LANES; i++) begin
        a = b + 16'(i);
        if (f == VST) begin
          exp_q.push_back({1'b1, a, v[i*16 +: 16]});
        end else begin
          exp_q.push_back({1'b0, a, 16'h0000});
          ld_model[i*16 +: 16] = a ^ 16'hA5A5;
        end
      end
    end
    d.fault    = flt;
    d.ld       = ld_model;
    d.done_cyc = (mode == 0) ? cyc + lat : -1;
    done_q.push_back(d);
    start        = 1'b1;
    functype     = f;
    base_addr    = b;
    scalar_wdata = s;
    vector_wdata = v;
    @(posedge clk);
    #1;
    start        = 1'b0;
    functype     = 4'($urandom);
    base_addr    = 16'($urandom);
    scalar_wdata = 16'($urandom);
    vector_wdata = {8{$urandom}};
  endtask

  task automatic wait_done();
    for (int k = 0; k < 400 && done_q.size() != 0; k++) @(posedge clk);
    check("op_timeout", done_q.size(), 0);
    done_q.delete();
    exp_q.delete();
    #1 check("busy_fall", busy, 1'b0);
  endtask

  task automatic issue_op(input logic [3:0] f, input logic [15:0] b, input logic [15:0] s,
                          input logic [255:0] v, input int mode, input bit poke);
    push_and_start(f, b, s, v, mode);
    if (poke) begin
      repeat (4) @(posedge clk);
      #1;
      start    = 1'b1;
      functype = VADD;
      @(posedge clk);
      #1 start = 1'b0;
    end
    wait_done();
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // main sequence
  initial begin
    logic [255:0] v;
    logic [3:0]   f;
    logic [15:0]  b;
    int           mode;
    int           c0;
    rst          = 1'b1;
    start        = 1'b0;
    functype     = NOP;
    base_addr    = '0;
    scalar_wdata = '0;
    vector_wdata = '0;
    #13;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_load_data", load_data, '0);
    #9 rst = 1'b0;

    issue_op(VLD, 16'h0100, 16'h0, '0, 0, 1'b0);
    for (int i = 0; i < LANES; i++) v[i*16 +: 16] = 16'h1000 + 16'(i);
    issue_op(VST, 16'h0200, 16'h0, v, 1, 1'b1);
    issue_op(SST, 16'h0030, 16'hBEEF, '0, 0, 1'b0);
    issue_op(VLD, 16'hFFF8, 16'h0, '0, 0, 1'b0);
    issue_op(VADD, 16'h1234, 16'h5678, '1, 0, 1'b0);

    // reset during the 7th word of a VLD
    c0 = xfer_cnt;
    push_and_start(VLD, 16'h0400, 16'h0, '0, 0);
    for (int k = 0; k < 100 && (xfer_cnt - c0) < 6; k++) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_mem_req", mem_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_load_data", load_data, '0);
    exp_q.delete();
    done_q.delete();
    ld_model = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    issue_op(VLD, 16'h0500, 16'h0, '0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: f = VLD;
        3, 4, 5: f = VST;
        6, 7:    f = SST;
        8:       f = VADD;
        default: f = 4'($urandom_range(6, 15));
      endcase
      b    = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      mode = $urandom_range(0, 2);
      issue_op(f, b, 16'($urandom), rand_vec(), mode,
               ((f == VLD) || (f == VST)) && (mode != 0) && (b <= 16'hFFF0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Multi-cycle controller for the memory-class instructions VLD, VST and SST.
- Receives the effective base address: the execute-stage sum of op1 (scalarData1) and op2 (sign-extended offset).
- Drives a 16-bit-wide data memory port with a req/ack handshake.
- VLD and VST each take 16 single-word transfers. SST takes one.
- Holds the pipeline via `busy` and pulses `done` on completion.

Parameters:
- LANES, 16, vector elements per 256-bit register.
- LANE_W, 16, bits per element and memory word width.
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request to begin an operation; sampled only in IDLE
- functype  in  4  instruction code: VLD=4'b0100, VST=4'b0101, SST=4'b0011
- base_addr  in  ADDR_W  effective address (op1+op2), sampled with start
- scalar_wdata  in  LANE_W  SST store data, sampled with start
- vector_wdata  in  LANES*LANE_W  VST store data; lane i = bits [16i+15:16i]; sampled with start
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  word address; valid while mem_req
- mem_wdata  out  LANE_W  write data; valid while mem_req && mem_we
- mem_rdata  in  LANE_W  read data; valid when mem_ack on a read
- mem_ack  in  1  transfer complete this cycle
- load_data  out  LANES*LANE_W  VLD assembly register, lane layout as for vector_wdata
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  address-overflow flag, valid with done

Behaviour:
- Reset, asynchronous:
  - State returns to IDLE.
  - mem_req, mem_we, done, busy, fault and the index counter go to 0.
  - mem_addr, mem_wdata and load_data go to 0.
  - A reset mid-transfer abandons the transfer immediately; no retry follows.
- States: IDLE, XFER, DONE.
- IDLE:
  - start=1 latches functype, base_addr, scalar_wdata and vector_wdata, clears idx, and moves to XFER.
  - If functype is not VLD, VST or SST, the block goes straight to DONE with no memory access.
- XFER, per cycle:
  - mem_req=1.
  - mem_addr = base+idx, modulo 2^16 (wraps from 0xFFFF to 0x0000).
  - mem_we=1 for VST and SST, 0 for VLD.
  - mem_wdata = vector lane idx for VST, scalar data for SST.
- XFER, on mem_ack=1:
  - For VLD, load_data lane idx <= mem_rdata.
  - idx increments.
  - mem_req stays high for the next word, so back-to-back transfers are allowed.
- XFER, end of transfer:
  - Last word: idx=15 for VLD/VST, idx=0 for SST.
  - The ack on the last word moves the state to DONE.
- mem_ack while mem_req=0 is ignored. With mem_ack=0, address and data are held stable.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- start while busy is ignored.
- Latency with mem_ack tied high:
  - start seen at edge 0.
  - VLD/VST: mem_req in cycles 1–16, done in cycle 17, busy falls in cycle 18.
  - SST: done in cycle 2.
  - Non-memory functype: done in cycle 1.
- load_data:
  - Updates lane by lane during a VLD.
  - Only guaranteed complete when done=1.
  - Holds its value until the next VLD writes it. VST and SST leave it unchanged.
- fault is 0 unless the optional feature is enabled.

Optional Feature:
- Macro: VSEQ_ADDR_FAULT_EN.
- Defined:
  - On start for VLD or VST, if base_addr + (LANES-1) carries out of ADDR_W, the block issues no memory access.
  - It goes to DONE with fault=1 for the done cycle.
  - SST never faults.
- Undefined:
  - Addresses wrap modulo 2^16.
  - fault is tied 0; the port remains.

Decomposition:
- Shared package `cvp14_pkg` holds:
  - functype localparams (VADD, VDOT, SMUL, SST, VLD, VST, SLL, SLH, J, NOP);
  - LANES and LANE_W;
  - the state enum type.
- One sub-module, `vseq_addr_gen`, is natural:
  - computes base+idx;
  - computes the carry-out of base+(LANES-1) used by the fault check.

Test Plan:
- VLD, base 0x0100, mem_ack tied 1, memory word at address A = A^16'hA5A5 → 16 reads at 0x0100..0x010F; done in cycle 17; load_data lane i = (0x0100+i)^0xA5A5.
- VST, base 0x0200, vector_wdata lane i = 0x1000+i, mem_ack pulsed every third cycle → 16 writes in order, addresses and data held stable while un-acked; done after the 16th ack; busy high throughout.
- SST, base 0x0030, scalar_wdata 0xBEEF → single write of 0xBEEF to 0x0030; done in cycle 2; load_data unchanged.
- VLD at base 0xFFF8:
  - macro off → addresses 0xFFF8..0xFFFF then 0x0000..0x0007; fault=0.
  - macro on → no mem_req; done with fault=1 in cycle 1.
- Reset asserted at the 7th transfer of a VLD → mem_req, busy and done drop asynchronously; load_data=0; a new VLD started afterwards completes normally.
- start during busy, and start with functype=VADD in IDLE → the busy start is ignored; VADD gives done in cycle 1 with no mem_req.
